aes_round_controller: RTL and testbench
=======================================

AES_ROUND_CONTROLLER -- requirements
Module: aes_round_controller

Interface
REQ-001 SHALL have parameter vecSize, default 4, giving the number of 32-bit state columns.
REQ-002 SHALL have parameter NUM_ROUNDS, default 10, giving the AES round count (AES-128).
REQ-003 SHALL have port clk, input, 1: the single clock; one clock; all state updates occur on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset; reset is synchronous and active-low.
REQ-005 SHALL have port start, input, 1: request to encrypt state_in; sampled only in IDLE.
REQ-006 SHALL have port state_in, input, vecSize x 32: plaintext block.
REQ-007 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-008 SHALL have port done, output, 1: single-cycle completion pulse.
REQ-009 SHALL have port state_out, output, vecSize x 32: working-state register; holds the ciphertext after done.
REQ-010 SHALL have port rk_rd_en, output, 1: round-key read strobe.
REQ-011 SHALL have port rk_addr, output, 4: round-key index.
REQ-012 SHALL have port rk_data, input, vecSize x 32: round key, valid exactly one cycle after rk_rd_en.
REQ-013 SHALL have port rnd_req, output, 1: request to the external SubBytes/ShiftRows/MixColumns unit.
REQ-014 SHALL have port rnd_last, output, 1: final round; the round unit skips MixColumns.
REQ-015 SHALL have port rnd_state, output, vecSize x 32: operand for the round unit; equals state_out.
REQ-016 SHALL have port rnd_ack, input, 1: round unit result valid.
REQ-017 SHALL have port rnd_result, input, vecSize x 32: round unit output.

Function
REQ-018 SHALL implement the FSM states IDLE, KEY_REQ, KEY_WAIT, ARK, RND and DONE.
REQ-019 SHALL, in IDLE with start=1, load state_out<=state_in, set round<=0 and go to KEY_REQ.
REQ-020 SHALL, in IDLE with start=0, remain in IDLE; start in any other state SHALL be ignored.
REQ-021 SHALL, in KEY_REQ, drive rk_rd_en=1 and rk_addr=round, then go to KEY_WAIT; rk_rd_en SHALL be 0 in all other states.
REQ-022 SHALL, in KEY_WAIT, capture rk_data into the internal key register, then go to ARK.
REQ-023 SHALL, in ARK, compute state_out<=state_out XOR key per 32-bit column using an add_round_key instance of width vecSize.
REQ-024 SHALL, in ARK, go to DONE if round==NUM_ROUNDS; otherwise set round<=round+1 and go to RND.
REQ-025 SHALL, in RND, hold rnd_req=1 and rnd_last=(round==NUM_ROUNDS) until the cycle in which rnd_ack=1.
REQ-026 SHALL, on the rnd_ack=1 edge, capture state_out<=rnd_result, drop rnd_req and go to KEY_REQ.
REQ-027 SHALL ignore rnd_ack outside RND.
REQ-028 SHALL, in DONE, assert done=1 for exactly one cycle, then go to IDLE.
REQ-029 SHALL hold state_out unchanged from DONE until the next accepted start.
REQ-030 SHALL keep round within 0..NUM_ROUNDS; round SHALL never wrap.
REQ-031 SHALL, with rnd_ack asserted in the first RND cycle, assert done in the 4*NUM_ROUNDS+4th cycle after the start-sampling edge (44 for the defaults).
REQ-032 SHALL add one cycle to the latency in REQ-031 for each RND cycle spent with rnd_ack=0.
REQ-033 SHALL register all outputs, with no combinational path from any input to any output.

Reset
REQ-034 SHALL, on any rising clk edge with rst_n=0, enter IDLE from any state, including mid-operation.
REQ-035 SHALL, on reset, clear round=0, key=0, state_out=0, busy=0, done=0, rk_rd_en=0, rk_addr=0, rnd_req=0 and rnd_last=0.
REQ-036 SHALL ignore start while rst_n=0.
REQ-037 SHALL accept a start on the first edge after rst_n returns to 1.

Verification
REQ-038 Bench SHALL cover FIPS-197 C.1: key 000102..0f in the key ROM model, round-unit model with zero-wait ack, state_in 00112233445566778899aabbccddeeff -> state_out 69c4e0d86a7b0430d8cdb78070b4c55a, with done in cycle 44.
REQ-039 Bench SHALL cover back-pressure: rnd_ack delayed 3 cycles in every round -> same ciphertext, done in cycle 74, rnd_req held high throughout each wait.
REQ-040 Bench SHALL cover rk_addr: rk_addr sequence 0,1,...,10, one rk_rd_en pulse each, rnd_last=1 only in round 10.
REQ-041 Bench SHALL cover start held high continuously: the block SHALL encrypt back-to-back, with the second start accepted in the cycle after done and busy low for exactly that IDLE cycle.
REQ-042 Bench SHALL cover reset mid-operation: rst_n=0 for one edge during round 5 RND -> all outputs zero next cycle, no done pulse, a fresh start produces the correct ciphertext.
REQ-043 Bench SHALL cover stray inputs: rnd_ack pulses in IDLE and KEY_WAIT, and start pulses while busy -> no state change and no extra done pulse.

Source files
------------

// File: rtl/aes_round_controller.sv
// AES round sequencer: key fetch, AddRoundKey, hands each round to an external round unit.
// Latency: done 4*NUM_ROUNDS+4 cycles after start, plus one cycle per RND cycle without rnd_ack.
// Backpressure: rnd_req is held until rnd_ack; start is only sampled while idle.
`timescale 1ns/1ps

module add_round_key #(
  parameter int vecSize = 4
) (
  input  logic [vecSize*32-1:0] state,
  input  logic [vecSize*32-1:0] key,
  output logic [vecSize*32-1:0] result
);

  for (genvar c = 0; c < vecSize; c++) begin : g_col
    assign result[c*32 +: 32] = state[c*32 +: 32] ^ key[c*32 +: 32];
  end

endmodule

module aes_round_controller #(
  parameter int vecSize    = 4,
  parameter int NUM_ROUNDS = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [vecSize*32-1:0] state_in,
  output logic                  busy,
  output logic                  done,
  output logic [vecSize*32-1:0] state_out,
  output logic                  rk_rd_en,
  output logic [3:0]            rk_addr,
  input  logic [vecSize*32-1:0] rk_data,
  output logic                  rnd_req,
  output logic                  rnd_last,
  output logic [vecSize*32-1:0] rnd_state,
  input  logic                  rnd_ack,
  input  logic [vecSize*32-1:0] rnd_result
);

  localparam int W = vecSize * 32;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] KEY_REQ  = 3'd1;
  localparam logic [2:0] KEY_WAIT = 3'd2;
  localparam logic [2:0] ARK      = 3'd3;
  localparam logic [2:0] RND      = 3'd4;
  localparam logic [2:0] DONE     = 3'd5;

  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

  logic [2:0]   state;
  logic [2:0]   state_nxt;
  logic [3:0]   round;
  logic [3:0]   round_nxt;
  logic [W-1:0] key;
  logic [W-1:0] ark_out;

  add_round_key #(
    .vecSize (vecSize)
  ) u_ark (
    .state  (state_out),
    .key    (key),
    .result (ark_out)
  );

  // The round unit always works on the live working state.
  assign rnd_state = state_out;

  always_comb begin
    state_nxt = state;
    round_nxt = round;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = KEY_REQ;
          round_nxt = '0;
        end
      end
      KEY_REQ:  state_nxt = KEY_WAIT;
      KEY_WAIT: state_nxt = ARK;
      ARK: begin
        if (round == LAST_RND) begin
          state_nxt = DONE;
        end else begin
          state_nxt = RND;
          round_nxt = round + 4'd1;
        end
      end
      RND: begin
        if (rnd_ack) state_nxt = KEY_REQ;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      round     <= '0;
      key       <= '0;
      state_out <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rk_rd_en  <= 1'b0;
      rk_addr   <= '0;
      rnd_req   <= 1'b0;
      rnd_last  <= 1'b0;
    end else begin
      state    <= state_nxt;
      round    <= round_nxt;
      busy     <= (state_nxt != IDLE);
      done     <= (state_nxt == DONE);
      rk_rd_en <= (state_nxt == KEY_REQ);
      rk_addr  <= round_nxt;
      rnd_req  <= (state_nxt == RND);
      rnd_last <= (state_nxt == RND) && (round_nxt == LAST_RND);

      if (state == KEY_WAIT) key <= rk_data;

      case (state)
        IDLE: begin
          if (start) state_out <= state_in;
        end
        ARK: state_out <= ark_out;
        RND: begin
          if (rnd_ack) state_out <= rnd_result;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_controller.sv
// Bench for aes_round_controller: key ROM and round-unit models, scoreboard of ciphertexts and done cycles.
`timescale 1ns/1ps

module tb_aes_round_controller;

  localparam int NR  = 10;
  localparam int LAT = 4 * NR + 4;
  localparam logic [127:0] JUNK   = 128'hdeadbeef_cafef00d_0badc0de_5a5a5a5a;
  localparam logic [127:0] PT_C1  = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;

  logic         clk = 1'b0;
  logic         rst_n, start;
  logic [127:0] state_in, rk_data, rnd_result, state_out, rnd_state;
  logic         busy, done, rk_rd_en, rnd_req, rnd_last, rnd_ack;
  logic [3:0]   rk_addr;

  aes_round_controller #(
    .vecSize    (4),
    .NUM_ROUNDS (NR)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .state_in   (state_in),
    .busy       (busy),
    .done       (done),
    .state_out  (state_out),
    .rk_rd_en   (rk_rd_en),
    .rk_addr    (rk_addr),
    .rk_data    (rk_data),
    .rnd_req    (rnd_req),
    .rnd_last   (rnd_last),
    .rnd_state  (rnd_state),
    .rnd_ack    (rnd_ack),
    .rnd_result (rnd_result)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- AES reference model ----------------
  logic [7:0]   sbox_tab [256];
  logic [127:0] rk_tab   [NR+1];

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xt(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  task automatic build_tables();
    logic [7:0]  inv, t, s, rcon;
    logic [31:0] w [44];
    logic [31:0] tw;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      t = inv;
      s = inv ^ 8'h63;
      for (int n = 0; n < 4; n++) begin
        t = {t[6:0], t[7]};
        s = s ^ t;
      end
      sbox_tab[x] = s;
    end
    w[0] = 32'h00010203; w[1] = 32'h04050607; w[2] = 32'h08090a0b; w[3] = 32'h0c0d0e0f;
    rcon = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tw = w[i-1];
      if (i % 4 == 0) begin
        tw = {tw[23:0], tw[31:24]};
        tw = {sbox_tab[tw[31:24]], sbox_tab[tw[23:16]], sbox_tab[tw[15:8]], sbox_tab[tw[7:0]]} ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ tw;
    end
    for (int r = 0; r <= NR; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic last);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sbox_tab[s[127-8*i -: 8]];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) t[r+4*c] = b[r + 4*((c+r)%4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
    return o;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ rk_tab[0];
    for (int r = 1; r <= NR; r++) s = aes_round(s, r == NR) ^ rk_tab[r];
    return s;
  endfunction

  // ---------------- key ROM and round-unit models ----------------
  int         ack_delay = 0;
  logic       stray_ack = 1'b0;
  int         wcnt      = 0;
  logic       rd_pend   = 1'b0;
  logic [3:0] addr_pend = 4'd0;

  initial begin
    rk_data    = JUNK;
    rnd_ack    = 1'b0;
    rnd_result = '0;
  end

  always @(negedge clk) begin
    // key is presented only in the cycle after the read strobe
    if (rd_pend) rk_data = (addr_pend <= 4'(NR)) ? rk_tab[addr_pend] : JUNK;
    else         rk_data = JUNK;
    rd_pend   = rk_rd_en;
    addr_pend = rk_addr;
    if (rnd_req === 1'b1) begin
      rnd_ack = (wcnt >= ack_delay);
      wcnt    = rnd_ack ? 0 : wcnt + 1;
    end else begin
      rnd_ack = 1'b0;
      wcnt    = 0;
    end
    rnd_ack    = rnd_ack | stray_ack;
    rnd_result = aes_round(rnd_state, rnd_last);
  end

  // ---------------- monitor logs ----------------
  int addr_log [$];
  int last_runs [$];
  int run_len_log [$];
  int runs = 0, runlen = 0, done_cnt = 0, busy_low_cnt = 0, stray_last = 0;

  always @(negedge clk) begin
    if (rk_rd_en === 1'b1) addr_log.push_back(int'(rk_addr));
    if (rnd_req === 1'b1) begin
      if (runlen == 0) begin
        runs++;
        if (rnd_last) last_runs.push_back(runs);
      end
      runlen++;
    end else if (runlen != 0) begin
      run_len_log.push_back(runlen);
      runlen = 0;
    end
    if (rnd_last === 1'b1 && rnd_req !== 1'b1) stray_last++;
    if (done === 1'b1) done_cnt++;
    if (busy === 1'b0) busy_low_cnt++;
  end

  // ---------------- scoreboard and stimulus helpers ----------------
  logic [127:0] exp_ct_q [$];
  int           exp_cyc_q [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    addr_log.delete(); last_runs.delete(); run_len_log.delete();
    runs = 0; done_cnt = 0; busy_low_cnt = 0; stray_last = 0;
  endtask

  task automatic issue(input logic [127:0] pt, input logic [127:0] ct, input int delay);
    state_in = pt;
    start    = 1'b1;
    exp_ct_q.push_back(ct);
    exp_cyc_q.push_back(cyc + LAT + NR * delay);
  endtask

  task automatic wait_done(output bit to, output logic [127:0] ct, output int dc);
    to = 1'b1; ct = '0; dc = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        to = 1'b0; ct = state_out; dc = cyc;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    state_in = {$urandom, $urandom, $urandom, $urandom};
    tick(); tick();
    tests++;
    if ({busy, done, rk_rd_en, rnd_req, rnd_last, rk_addr, state_out, rnd_state} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: busy=%b done=%b rd=%b req=%b last=%b addr=%0d out=%h want all zero",
               busy, done, rk_rd_en, rnd_req, rnd_last, rk_addr, state_out);
    end
    start = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fips_c1();
    bit to; logic [127:0] ct, ect; int dc, ecyc; bit ok;
    clear_logs();
    ack_delay = 0;
    issue(PT_C1, CT_C1, 0);
    tick();
    start = 1'b0;
    wait_done(to, ct, dc);
    ect = exp_ct_q.pop_front(); ecyc = exp_cyc_q.pop_front();
    tests++;
    if (to) begin fails++; $display("FAIL c1_timeout: no done within 400 cycles"); end
    tests++;
    if (ct !== ect) begin fails++; $display("FAIL c1_ciphertext: got %h want %h", ct, ect); end
    tests++;
    if (dc !== ecyc) begin fails++; $display("FAIL c1_done_cycle: got %0d want %0d", dc, ecyc); end
    repeat (5) tick();
    tests++;
    if (state_out !== ect || busy !== 1'b0) begin
      fails++; $display("FAIL c1_hold: state_out=%h busy=%b want %h busy=0", state_out, busy, ect);
    end
    ok = (addr_log.size() == NR + 1);
    if (ok) for (int i = 0; i <= NR; i++) if (addr_log[i] != i) ok = 1'b0;
    tests++;
    if (!ok) begin fails++; $display("FAIL rk_addr_seq: got %0d strobes (%p) want 0..%0d once each", addr_log.size(), addr_log, NR); end
    tests++;
    if (last_runs.size() != 1 || last_runs[0] != NR || runs != NR || stray_last != 0) begin
      fails++; $display("FAIL rnd_last: runs=%0d last_in=%p stray=%0d want runs=%0d last only in %0d", runs, last_runs, stray_last, NR, NR);
    end
    tests++;
    if (done_cnt != 1) begin fails++; $display("FAIL c1_done_pulses: got %0d want 1", done_cnt); end
  endtask

  task automatic test_backpressure();
    bit to; logic [127:0] ct, ect, pt; int dc, ecyc; bit ok;
    clear_logs();
    ack_delay = 3;
    pt = {$urandom, $urandom, $urandom, $urandom};
    issue(pt, aes_enc(pt), 3);
    tick();
    start = 1'b0;
    wait_done(to, ct, dc);
    ect = exp_ct_q.pop_front(); ecyc = exp_cyc_q.pop_front();
    tests++;
    if (to) begin fails++; $display("FAIL bp_timeout: no done within 400 cycles"); end
    tests++;
    if (ct !== ect) begin fails++; $display("FAIL bp_ciphertext: got %h want %h", ct, ect); end
    tests++;
    if (dc !== ecyc) begin fails++; $display("FAIL bp_done_cycle: got %0d want %0d", dc, ecyc); end
    tick();
    ok = (run_len_log.size() == NR);
    foreach (run_len_log[i]) if (run_len_log[i] != 4) ok = 1'b0;
    tests++;
    if (!ok) begin fails++; $display("FAIL bp_req_hold: rnd_req run lengths %p want %0d runs of 4", run_len_log, NR); end
    ack_delay = 0;
  endtask

  task automatic test_back_to_back();
    bit to; logic [127:0] ct, ect, pa, pb; int dc, ecyc, p0;
    clear_logs();
    pa = {$urandom, $urandom, $urandom, $urandom};
    pb = {$urandom, $urandom, $urandom, $urandom};
    p0 = cyc;
    issue(pa, aes_enc(pa), 0);
    exp_ct_q.push_back(aes_enc(pb));
    exp_cyc_q.push_back(p0 + 2 * LAT + 1);
    tick();
    state_in = pb;
    wait_done(to, ct, dc);
    busy_low_cnt = 0;
    ect = exp_ct_q.pop_front(); ecyc = exp_cyc_q.pop_front();
    tests++;
    if (to || ct !== ect || dc !== ecyc) begin
      fails++; $display("FAIL b2b_first: to=%0b ct=%h cyc=%0d want ct=%h cyc=%0d", to, ct, dc, ect, ecyc);
    end
    tick(); tick(); tick();
    start = 1'b0;
    wait_done(to, ct, dc);
    ect = exp_ct_q.pop_front(); ecyc = exp_cyc_q.pop_front();
    tests++;
    if (to) begin fails++; $display("FAIL b2b_timeout: second done missing"); end
    tests++;
    if (ct !== ect) begin fails++; $display("FAIL b2b_second_ct: got %h want %h", ct, ect); end
    tests++;
    if (dc !== ecyc) begin fails++; $display("FAIL b2b_second_cycle: got %0d want %0d", dc, ecyc); end
    tests++;
    if (busy_low_cnt != 1) begin fails++; $display("FAIL b2b_idle_gap: busy low %0d cycles want 1", busy_low_cnt); end
    tick();
  endtask

  task automatic test_reset_mid();
    bit to, prev; logic [127:0] ct, ect, pt; int dc, ecyc, nr, d0;
    clear_logs();
    pt = {$urandom, $urandom, $urandom, $urandom};
    issue(pt, aes_enc(pt), 0);
    tick();
    start = 1'b0;
    prev = 1'b0; nr = 0;
    for (int i = 0; i < 200; i++) begin
      if (rnd_req && !prev) nr++;
      prev = rnd_req;
      if (nr == 5) break;
      tick();
    end
    tests++;
    if (nr != 5) begin fails++; $display("FAIL rst_mid_reach: saw %0d rounds want 5", nr); end
    rst_n = 1'b0;
    tick();
    tests++;
    if ({busy, done, rk_rd_en, rnd_req, rnd_last, rk_addr, state_out, rnd_state} !== '0) begin
      fails++;
      $display("FAIL rst_mid_outputs: busy=%b done=%b rd=%b req=%b last=%b addr=%0d out=%h want all zero",
               busy, done, rk_rd_en, rnd_req, rnd_last, rk_addr, state_out);
    end
    exp_ct_q.delete(); exp_cyc_q.delete();
    rst_n = 1'b1;
    d0 = done_cnt;
    pt = {$urandom, $urandom, $urandom, $urandom};
    issue(pt, aes_enc(pt), 0);
    tick();
    start = 1'b0;
    wait_done(to, ct, dc);
    ect = exp_ct_q.pop_front(); ecyc = exp_cyc_q.pop_front();
    tests++;
    if (to || ct !== ect) begin fails++; $display("FAIL rst_mid_restart_ct: to=%0b got %h want %h", to, ct, ect); end
    tests++;
    if (dc !== ecyc) begin fails++; $display("FAIL rst_mid_restart_cycle: got %0d want %0d", dc, ecyc); end
    tick(); tick();
    tests++;
    if (done_cnt - d0 != 1) begin fails++; $display("FAIL rst_mid_done_pulses: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_stray();
    bit to; logic [127:0] ct, ect, pt, so; int dc, ecyc, k;
    clear_logs();
    so = state_out;
    stray_ack = 1'b1;
    tick(); tick();
    stray_ack = 1'b0;
    tick(); tick();
    tests++;
    if (busy !== 1'b0 || state_out !== so || done_cnt != 0) begin
      fails++; $display("FAIL stray_idle_ack: busy=%b out=%h dones=%0d want busy=0 out=%h dones=0", busy, state_out, done_cnt, so);
    end
    pt = {$urandom, $urandom, $urandom, $urandom};
    issue(pt, aes_enc(pt), 0);
    tick();
    start = 1'b0;
    k = 0;
    for (int i = 0; i < 200; i++) begin
      if (rk_rd_en) begin
        k++;
        if (k == 2 || k == 6) begin
          tick(); stray_ack = 1'b1;
          tick(); stray_ack = 1'b0;
        end else if (k == 4) begin
          start = 1'b1; state_in = JUNK;
          tick(); tick();
          start = 1'b0;
        end
        if (k == 8) break;
      end
      tick();
    end
    wait_done(to, ct, dc);
    ect = exp_ct_q.pop_front(); ecyc = exp_cyc_q.pop_front();
    tests++;
    if (to || ct !== ect) begin fails++; $display("FAIL stray_busy_ct: to=%0b got %h want %h", to, ct, ect); end
    tests++;
    if (dc !== ecyc) begin fails++; $display("FAIL stray_busy_cycle: got %0d want %0d", dc, ecyc); end
    repeat (4) tick();
    tests++;
    if (done_cnt != 1 || busy !== 1'b0) begin fails++; $display("FAIL stray_done_pulses: got %0d busy=%b want 1 busy=0", done_cnt, busy); end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    state_in = '0;
    build_tables();
    test_reset();
    test_fips_c1();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_stray();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
